booth_mul_share_arb: RTL and testbench

- Shares one combinational signed Booth multiplier, `booth_multiplier_8_PPA_Brent_Kung`, among NREQ independent requesters.
- Arbitrates round-robin, captures the winner's operands and sequences one multiply.
- Returns the product tagged with the requester ID over a valid/ready response channel.
- Sits between multiple datapath clients and the single multiplier instance.

---
 rtl/booth_mul_share_arb.sv | 173 +++++++++++++++++
 tb/tb_booth_mul_share_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_share_arb.sv
// Round-robin arbiter sharing one combinational radix-4 Booth multiplier among
// NREQ requesters; products return tagged with the requester index.

module booth_multiplier_8_PPA_Brent_Kung #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);
    localparam int PW   = 2 * WIDTH;
    localparam int WB   = WIDTH + (WIDTH % 2);
    localparam int NDIG = WB / 2;

    logic signed [WB-1:0] b_ext;
    logic        [WB:0]   b_win;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] pp;
    logic signed [PW-1:0] acc;
    logic        [2:0]    dig;

    always_comb begin
        b_ext = WB'(b);
        b_win = {b_ext, 1'b0};
        a_ext = PW'(a);
        acc   = '0;
        pp    = '0;
        dig   = '0;
        // each overlapping 3-bit window selects 0, +-A or +-2A at weight 4^i
        for (int unsigned i = 0; i < NDIG; i++) begin
            dig = b_win[2*i +: 3];
            case (dig)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2 * i));
        end
        p = acc;
    end
endmodule

module booth_mul_share_arb #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    parameter  int CNTW  = 16,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  busy,
    output logic [CNTW-1:0]       done_cnt
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t                    state_q, state_d;
    logic        [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic signed [WIDTH-1:0]   op_a_q, op_a_d;
    logic signed [WIDTH-1:0]   op_b_q, op_b_d;
    logic        [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic        [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic        [2*WIDTH-1:0] rsp_product_q, rsp_product_d;
    logic        [CNTW-1:0]    done_cnt_q, done_cnt_d;

    logic                      win_found;
    logic        [IDW-1:0]     win_idx;
    logic signed [2*WIDTH-1:0] mul_p;

    booth_multiplier_8_PPA_Brent_Kung #(.WIDTH(WIDTH)) u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (mul_p)
    );

    // first valid requester scanning upward from rr_ptr, wrapping at NREQ
    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] idx_w;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= 32'(NREQ)) idx = idx - 32'(NREQ);
            idx_w = IDW'(idx);
            if (!win_found && req_valid[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        gnt_id_d      = gnt_id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        done_cnt_d    = done_cnt_q;
        req_ready     = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = rst_n;
                    op_a_d   = req_a[win_idx*WIDTH +: WIDTH];
                    op_b_d   = req_b[win_idx*WIDTH +: WIDTH];
                    gnt_id_d = win_idx;
                    rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                    state_d  = MUL;
                end
            end
            MUL: begin
                rsp_product_d = mul_p;
                rsp_id_d      = gnt_id_q;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CNTW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            gnt_id_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            done_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            gnt_id_q      <= gnt_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            done_cnt_q    <= done_cnt_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign done_cnt    = done_cnt_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_booth_mul_share_arb.sv
// Randomized and directed bench for booth_mul_share_arb against a
// transaction-level model (pending job + age since grant).

module tb_booth_mul_share_arb;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int CNTW  = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid, rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  busy;
    logic [CNTW-1:0]       done_cnt;

    booth_mul_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_product(rsp_product),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    // model: one pending job, age 1 = being multiplied, age 2 = offered
    bit          m_have;
    int          m_age, m_rr, m_txn_id;
    logic [15:0] m_txn_prod, m_out_prod, m_done;
    logic [1:0]  m_out_id;

    always @(posedge clk) begin
        int w;
        int p;
        if (!rst_n) begin
            m_have <= 0; m_age <= 0; m_rr <= 0; m_done <= '0;
            m_out_prod <= '0; m_out_id <= '0; m_txn_id <= 0; m_txn_prod <= '0;
        end else if (!m_have) begin
            w = winner(req_valid, m_rr);
            if (w >= 0) begin
                p = int'($signed(req_a[w*WIDTH +: WIDTH])) * int'($signed(req_b[w*WIDTH +: WIDTH]));
                m_txn_prod <= p[15:0];
                m_txn_id   <= w;
                m_have     <= 1;
                m_age      <= 1;
                m_rr       <= (w + 1) % NREQ;
            end
        end else if (m_age == 1) begin
            m_age      <= 2;
            m_out_prod <= m_txn_prod;
            m_out_id   <= 2'(m_txn_id);
        end else if (rsp_ready) begin
            m_have <= 0;
            m_done <= m_done + 16'd1;
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] e_rdy;
        int w;
        if (chk_en) begin
            e_rdy = '0;
            w = winner(req_valid, m_rr);
            if (rst_n && !m_have && w >= 0) e_rdy[w] = 1'b1;
            check("req_ready",   32'(req_ready),   32'(e_rdy));
            check("busy",        32'(busy),        32'(m_have));
            check("rsp_valid",   32'(rsp_valid),   32'(m_have && m_age == 2));
            check("rsp_id",      32'(rsp_id),      32'(m_out_id));
            check("rsp_product", 32'(rsp_product), 32'(m_out_prod));
            check("done_cnt",    32'(done_cnt),    32'(m_done));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int n = 0; n < 30 && busy !== 1'b0; n++) tick();
        if (busy !== 1'b0) timeout("wait_idle");
    endtask

    task automatic run_one(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input bit mutate);
        int lat;
        wait_idle();
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        #1 check("grant_onehot", 32'(req_ready), 32'(req_valid));
        tick();
        req_valid = '0;
        if (mutate) req_a[idx*WIDTH +: WIDTH] = a + 8'd95;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 6) begin
            tick();
            lat++;
        end
        if (rsp_valid !== 1'b1) timeout("rsp_wait");
        check("latency",   32'(lat), 32'd2);
        check("dir_id",    32'(rsp_id), 32'(idx));
        check("dir_prod",  32'(rsp_product), 32'(exp));
        tick();
    endtask

    initial begin
        int gnt_cyc[$];
        int rsp_ids[$];
        logic [15:0] rsp_prods[$];
        logic [15:0] d0;

        rst_n = 0; req_valid = '1; rsp_ready = 0;
        req_a = $urandom; req_b = $urandom;
        tick(); tick();
        chk_en = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_product",   32'(rsp_product), 32'd0);
        check("rst_done",      32'(done_cnt), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        rst_n = 1; rsp_ready = 1;
        #1 check("first_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_idle();

        run_one(2, 8'sd7, 8'hFD, 16'hFFEB, 0);
        check("done_after_two", 32'(done_cnt), 32'd2);
        run_one(0, 8'h80, 8'h80, 16'h4000, 0);
        run_one(3, 8'h80, 8'h7F, 16'hC080, 0);
        run_one(1, 8'hFF, 8'hFF, 16'h0001, 0);
        run_one(2, 8'h00, 8'h80, 16'h0000, 0);

        // round robin from a fresh pointer
        wait_idle();
        rst_n = 0; tick(); rst_n = 1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 8'(i + 1);
            req_b[i*WIDTH +: WIDTH] = 8'd10;
        end
        req_valid = '1; rsp_ready = 1;
        for (int n = 0; n < 40 && rsp_ids.size() < 6; n++) begin
            #1;
            if (req_ready != '0) gnt_cyc.push_back(cyc);
            if (rsp_valid) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_prods.push_back(rsp_product);
            end
            tick();
        end
        req_valid = '0;
        if (rsp_ids.size() < 6) timeout("rr_responses");
        else for (int k = 0; k < 6; k++) begin
            check("rr_id",   32'(rsp_ids[k]), 32'(k % 4));
            check("rr_prod", 32'(rsp_prods[k]), 32'(10 * (k % 4 + 1)));
        end
        for (int k = 0; k + 1 < gnt_cyc.size(); k++)
            check("rr_gap", 32'(gnt_cyc[k+1] - gnt_cyc[k]), 32'd3);

        // backpressure
        wait_idle();
        rsp_ready = 0;
        req_valid = 4'b1000;
        req_a[3*WIDTH +: WIDTH] = 8'hFB;
        req_b[3*WIDTH +: WIDTH] = 8'd9;
        tick();
        req_valid = '1;
        for (int n = 0; n < 6 && rsp_valid !== 1'b1; n++) tick();
        if (rsp_valid !== 1'b1) timeout("bp_wait");
        d0 = done_cnt;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_prod",  32'(rsp_product), 32'hFFD3);
            check("bp_id",    32'(rsp_id), 32'd3);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_done",  32'(done_cnt), 32'(d0));
            tick();
        end
        req_valid = '0; rsp_ready = 1;
        tick();
        check("bp_done_inc", 32'(done_cnt), 32'(d0 + 16'd1));
        check("bp_released", 32'(rsp_valid), 32'd0);

        // reset while a response is pending
        wait_idle();
        rsp_ready = 0;
        req_valid = 4'b0010;
        req_a[1*WIDTH +: WIDTH] = 8'd5;
        req_b[1*WIDTH +: WIDTH] = 8'd6;
        tick();
        req_valid = '0;
        req_a[1*WIDTH +: WIDTH] = 8'd100;
        tick();
        check("pre_rst_prod", 32'(rsp_product), 32'd30);
        rst_n = 0; tick(); rst_n = 1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_done",  32'(done_cnt), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        req_valid = '1;
        #1 check("mid_rst_rr", 32'(req_ready), 32'b0001);
        req_valid = '0;
        rsp_ready = 1;
        run_one(1, 8'd5, 8'd6, 16'd30, 1);

        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 60) != 0);
            req_valid = NREQ'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_n = 1; req_valid = '0; rsp_ready = 1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
